// File: rtl/csel_adder_pipe_if.sv
// csel_adder_pipe_if: operand/result bundle for the pipelined carry-select
// adder.
//
// Optional feature macro: CSEL_ADDER_SAT_EN adds the 'sat' request bit,
// which travels with the operands.
//
// Signals:
//   in_valid/in_ready       operand handshake (producer -> adder)
//   a, b, cin, sub, [sat]   operands and mode, qualified by in_valid
//   out_valid/out_ready     result handshake (adder -> consumer)
//   sum, cout, overflow, zero  result and flags, qualified by out_valid
// Modports:
//   master  the operand producer / result consumer (testbench side)
//   slave   the adder itself
interface csel_adder_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
`ifdef CSEL_ADDER_SAT_EN
  logic             sat;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             zero;

`ifdef CSEL_ADDER_SAT_EN
  modport master (
    output in_valid, a, b, cin, sub, sat, out_ready,
    input  in_ready, out_valid, sum, cout, overflow, zero
  );
  modport slave (
    input  in_valid, a, b, cin, sub, sat, out_ready,
    output in_ready, out_valid, sum, cout, overflow, zero
  );
`else
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, overflow, zero
  );
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, overflow, zero
  );
`endif
endinterface

// File: rtl/csel_adder_pipe.sv
// csel_adder_pipe: parametrised, pipelined carry-select adder/subtractor
// with valid/ready flow control and carry/overflow/zero flags.
//
// Optional feature macro: CSEL_ADDER_SAT_EN. When it is defined, a 'sat'
// bit travels with each operation. If it is set, a signed overflow clamps
// the sum to the largest positive or negative value. When the macro is
// undefined, results always wrap.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; discards everything in flight
//   bus    csel_adder_pipe_if.slave
//          operands in:  in_valid/in_ready, a, b, cin, sub, [sat]
//          results out:  out_valid/out_ready, sum, cout, overflow, zero
//
// Structure: the NBLK = WIDTH/BLK blocks are split evenly over STAGES
// register stages. Stage k resolves its blocks from the carry handed
// over by stage k-1. The last stage writes the output register, so the
// latency is exactly STAGES cycles. A single global stall (advance)
// freezes every stage while a result waits for out_ready.
module csel_adder_pipe #(
  parameter int WIDTH  = 32,
  parameter int BLK    = 4,
  parameter int STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  csel_adder_pipe_if.slave     bus
);
  localparam int NBLK = WIDTH / BLK;
  localparam int BPS  = NBLK / STAGES;   // blocks resolved per stage
  localparam int MSB  = WIDTH - 1;
  localparam int LAST = STAGES - 1;

  // Stage registers. Entry LAST is never loaded, because the last stage
  // feeds the output register directly.
  logic             v_reg   [STAGES];
  logic [WIDTH-1:0] sum_reg [STAGES];   // low bits resolved so far
  logic [WIDTH-1:0] a_reg   [STAGES];
  logic [WIDTH-1:0] bx_reg  [STAGES];   // b already conditioned for sub
  logic             c_reg   [STAGES];   // carry into the next stage
`ifdef CSEL_ADDER_SAT_EN
  logic             sat_reg [STAGES];
`endif

  // Output register
  logic             out_valid_reg;
  logic [WIDTH-1:0] out_sum_reg;
  logic             cout_reg;
  logic             ovf_reg;
  logic             zero_reg;

  // Next-state values produced by each stage's combinational slice
  logic             nx_v   [STAGES];
  logic [WIDTH-1:0] nx_sum [STAGES];
  logic [WIDTH-1:0] nx_a   [STAGES];
  logic [WIDTH-1:0] nx_bx  [STAGES];
  logic             nx_c   [STAGES];
`ifdef CSEL_ADDER_SAT_EN
  logic             nx_sat [STAGES];
  logic             src_sat;
`endif

  logic             src_v;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_bx;
  logic [WIDTH-1:0] src_sum;
  logic             carry;
  logic [BLK:0]     s0;
  logic [BLK:0]     s1;
  logic [BLK:0]     r;
  int               pk;

  logic [WIDTH-1:0] fin_sum;
  logic             fin_ovf;
  logic             fin_zero;
  logic             fin_cout;

  logic             advance;
  logic [WIDTH-1:0] in_bx;
  logic             in_c0;

  // Subtraction is a + ~b + 1. The carry-in is inverted so that
  // sub=1, cin=1 yields a-b-1 (borrow-in).
  assign in_bx = bus.b ^ {WIDTH{bus.sub}};
  assign in_c0 = bus.cin ^ bus.sub;

  // Global stall: the pipeline moves only when the output slot is free
  // or is being drained in this cycle.
  assign advance      = !out_valid_reg || bus.out_ready;
  assign bus.in_ready = advance;

  always_comb begin
    src_v    = 1'b0;
    src_a    = '0;
    src_bx   = '0;
    src_sum  = '0;
    carry    = 1'b0;
    s0       = '0;
    s1       = '0;
    r        = '0;
    pk       = 0;
`ifdef CSEL_ADDER_SAT_EN
    src_sat  = 1'b0;
`endif
    for (int k = 0; k < STAGES; k++) begin
      pk = (k > 0) ? k - 1 : 0;
      if (k == 0) begin
        src_v   = bus.in_valid;
        src_a   = bus.a;
        src_bx  = in_bx;
        src_sum = '0;
        carry   = in_c0;
`ifdef CSEL_ADDER_SAT_EN
        src_sat = bus.sat;
`endif
      end else begin
        src_v   = v_reg[pk];
        src_a   = a_reg[pk];
        src_bx  = bx_reg[pk];
        src_sum = sum_reg[pk];
        carry   = c_reg[pk];
`ifdef CSEL_ADDER_SAT_EN
        src_sat = sat_reg[pk];
`endif
      end
      for (int j = 0; j < BPS; j++) begin
        // Both candidate sums are formed from the operands alone. Only the
        // select depends on the incoming carry, which keeps the
        // carry-dependent path to one mux per block.
        s0 = {1'b0, src_a[(k*BPS+j)*BLK +: BLK]}
           + {1'b0, src_bx[(k*BPS+j)*BLK +: BLK]};
        s1 = s0 + {{BLK{1'b0}}, 1'b1};
        if (k * BPS + j == 0)
          r = s0 + {{BLK{1'b0}}, carry};   // block 0: plain ripple with c0
        else
          r = carry ? s1 : s0;
        src_sum[(k*BPS+j)*BLK +: BLK] = r[BLK-1:0];
        carry = r[BLK];
      end
      nx_v[k]   = src_v;
      nx_sum[k] = src_sum;
      nx_a[k]   = src_a;
      nx_bx[k]  = src_bx;
      nx_c[k]   = carry;
`ifdef CSEL_ADDER_SAT_EN
      nx_sat[k] = src_sat;
`endif
    end

    // Flags are computed on the fully resolved sum of the last stage.
    fin_cout = nx_c[LAST];
    fin_sum  = nx_sum[LAST];
    fin_ovf  = (nx_a[LAST][MSB] == nx_bx[LAST][MSB]) &&
               (nx_sum[LAST][MSB] != nx_a[LAST][MSB]);
`ifdef CSEL_ADDER_SAT_EN
    // Clamp toward the sign of a. Both operands share that sign whenever
    // an overflow is possible.
    if (nx_sat[LAST] && fin_ovf)
      fin_sum = nx_a[LAST][MSB] ? {1'b1, {(WIDTH-1){1'b0}}}
                                : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    fin_zero = (fin_sum == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        v_reg[k]   <= 1'b0;
        sum_reg[k] <= '0;
        a_reg[k]   <= '0;
        bx_reg[k]  <= '0;
        c_reg[k]   <= 1'b0;
`ifdef CSEL_ADDER_SAT_EN
        sat_reg[k] <= 1'b0;
`endif
      end
      out_valid_reg <= 1'b0;
      out_sum_reg   <= '0;
      cout_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
      zero_reg      <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < LAST; k++) begin
        v_reg[k]   <= nx_v[k];
        sum_reg[k] <= nx_sum[k];
        a_reg[k]   <= nx_a[k];
        bx_reg[k]  <= nx_bx[k];
        c_reg[k]   <= nx_c[k];
`ifdef CSEL_ADDER_SAT_EN
        sat_reg[k] <= nx_sat[k];
`endif
      end
      out_valid_reg <= nx_v[LAST];
      out_sum_reg   <= fin_sum;
      cout_reg      <= fin_cout;
      ovf_reg       <= fin_ovf;
      zero_reg      <= fin_zero;
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.sum       = out_sum_reg;
  assign bus.cout      = cout_reg;
  assign bus.overflow  = ovf_reg;
  assign bus.zero      = zero_reg;

endmodule

// File: tb/tb_csel_adder_pipe.sv
// tb_csel_adder_pipe: self-checking bench for csel_adder_pipe
// (WIDTH=32, BLK=4, STAGES=2).
//
// Stimulus sources:
//   - a table of directed vectors with hand-computed results
//   - 100 random back-to-back operations
//   - random backpressure, starting with a 3-cycle hold of out_ready=0
//   - a reset asserted while operations are in flight
//
// Expected results are pushed to a scoreboard queue when an operation is
// accepted. A monitor compares the front entry every cycle that out_valid
// is high, so stalled outputs are also checked, and pops it on handshake.
// Build with +define+CSEL_ADDER_SAT_EN to cover the saturation vectors.
module tb_csel_adder_pipe;
  localparam int WIDTH  = 32;
  localparam int BLK    = 4;
  localparam int STAGES = 2;
`ifdef CSEL_ADDER_SAT_EN
  localparam bit SAT_BUILD = 1'b1;
`else
  localparam bit SAT_BUILD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  csel_adder_pipe_if #(.WIDTH(WIDTH)) bus ();

  csel_adder_pipe #(.WIDTH(WIDTH), .BLK(BLK), .STAGES(STAGES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        lat_chk;
    int          acc_cyc;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        sat;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   stalls = 0;
  bit   front_seen = 1'b0;
  bit   lat_on = 1'b0;
  bit   bp_run = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: plain wide addition, independent of block structure.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub,
                                 input logic sat);
    exp_t        m;
    logic [32:0] t;
    logic [31:0] bx;
    bx = b ^ {32{sub}};
    t  = {1'b0, a} + {1'b0, bx} + {32'b0, cin ^ sub};
    m.sum  = t[31:0];
    m.cout = t[32];
    m.ovf  = (a[31] == bx[31]) && (t[31] != a[31]);
    if (SAT_BUILD && sat && m.ovf)
      m.sum = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    m.zero    = (m.sum == 32'h0);
    m.lat_chk = 1'b0;
    m.acc_cyc = 0;
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Drive one operation and hold it until in_ready. Acceptance is then
  // certain at the next rising edge, because out_ready only changes on
  // falling edges.
  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic cin, input logic sub, input logic sat,
                      input exp_t e);
    bit ok;
    exp_t ee;
    ok = 1'b0;
    ee = e;
    for (int w = 0; w < 100; w++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a   = a;
      bus.b   = b;
      bus.cin = cin;
      bus.sub = sub;
`ifdef CSEL_ADDER_SAT_EN
      bus.sat = sat;
`endif
      #1;
      if (bus.in_ready) begin
        ee.acc_cyc = cyc;
        ee.lat_chk = lat_on;
        sb.push_back(ee);
        ok = 1'b1;
        $display("TX a=%h b=%h cin=%0d sub=%0d sat=%0d exp_sum=%h", a, b, cin, sub, sat, ee.sum);
        break;
      end
      stalls++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=in_ready stuck low required=accept within 100 cycles");
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic drain(input int budget);
    for (int w = 0; w < budget && sb.size() != 0; w++) idle(1);
    chk("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: samples 2 time units after each falling edge, well away
  // from the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual sum=%h required=no output", bus.sum);
        end else begin
          e = sb[0];
          chk("sum",      bus.sum,            e.sum);
          chk("cout",     32'(bus.cout),      32'(e.cout));
          chk("overflow", 32'(bus.overflow),  32'(e.ovf));
          chk("zero",     32'(bus.zero),      32'(e.zero));
          if (e.lat_chk && !front_seen)
            chk("latency", 32'(cyc - e.acc_cyc), 32'(STAGES));
          front_seen = 1'b1;
          if (!bus.out_ready) begin
            chk("in_ready_stall", 32'(bus.in_ready), 32'd0);
          end else begin
            void'(sb.pop_front());
            front_seen = 1'b0;
            $display("RX sum=%h cout=%0d ovf=%0d zero=%0d", bus.sum, bus.cout, bus.overflow, bus.zero);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [31:0] ra, rb;
    logic rc, rs, rt;

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
`ifdef CSEL_ADDER_SAT_EN
    bus.sat       = 1'b0;
`endif
    bus.out_ready = 1'b1;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_sum",       bus.sum,            32'd0);
    chk("rst_cout",      32'(bus.cout),      32'd0);
    chk("rst_overflow",  32'(bus.overflow),  32'd0);
    chk("rst_zero",      32'(bus.zero),      32'd0);
    rst_n = 1'b1;
    idle(3);
    #1;
    chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
    chk("idle_in_ready",  32'(bus.in_ready),  32'd1);

    // Directed vectors: a, b, cin, sub, sat, sum, cout, ovf, zero
    tbl.push_back('{32'hFFFF_FFFF, 32'h1,         1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1});
    tbl.push_back('{32'h7FFF_FFFF, 32'h1,         1'b0, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{32'h5,         32'h7,         1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{32'h7,         32'h5,         1'b0, 1'b1, 1'b0, 32'h2,         1'b1, 1'b0, 1'b0});
    tbl.push_back('{32'h7,         32'h5,         1'b1, 1'b1, 1'b0, 32'h1,         1'b1, 1'b0, 1'b0});
    tbl.push_back('{32'hF,         32'h1,         1'b1, 1'b0, 1'b0, 32'h11,        1'b0, 1'b0, 1'b0});
    tbl.push_back('{32'h0FFF_FFFF, 32'h1,         1'b0, 1'b0, 1'b0, 32'h1000_0000, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1});
    tbl.push_back('{32'h0,         32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1});
    tbl.push_back('{32'h8000_0000, 32'h1,         1'b0, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0});
`ifdef CSEL_ADDER_SAT_EN
    tbl.push_back('{32'h8000_0000, 32'h1,         1'b0, 1'b1, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{32'h7FFF_FFFF, 32'h1,         1'b0, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0});
`endif

    // The first vector enters an empty pipeline. With out_ready held high,
    // every table entry must appear exactly STAGES cycles after acceptance.
    lat_on = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      e.sum  = tbl[i].sum;
      e.cout = tbl[i].cout;
      e.ovf  = tbl[i].ovf;
      e.zero = tbl[i].zero;
      e.lat_chk = 1'b0;
      e.acc_cyc = 0;
      send(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, tbl[i].sat, e);
    end
    idle(1);
    drain(STAGES + 3);

    // 100 random back-to-back operations with no backpressure
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      ra = $urandom;
      rb = (i % 8 == 0) ? ~ra : $urandom;
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      rt = 1'($urandom_range(0, 1));
      send(ra, rb, rc, rs, rt, model(ra, rb, rc, rs, rt));
    end
    idle(1);
    chk("b2b_stalls", 32'(stalls), 32'd0);
    drain(STAGES + 2);
    lat_on = 1'b0;

    // Random backpressure, starting with out_ready held low for 3 cycles
    bp_run = 1'b1;
    fork
      begin
        repeat (3) begin
          @(negedge clk);
          bus.out_ready = 1'b0;
        end
        while (bp_run) begin
          @(negedge clk);
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int i = 0; i < 60; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      rt = 1'($urandom_range(0, 1));
      send(ra, rb, rc, rs, rt, model(ra, rb, rc, rs, rt));
    end
    idle(1);
    bp_run = 1'b0;
    repeat (2) @(negedge clk);
    bus.out_ready = 1'b1;
    drain(60);

    // Reset with two operations in flight. Neither may ever emerge.
    send(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 1'b0, model(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 1'b0));
    send(32'h3333_3333, 32'h1,         1'b0, 1'b1, 1'b0, model(32'h3333_3333, 32'h1,         1'b0, 1'b1, 1'b0));
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    sb.delete();
    front_seen = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_sum",       bus.sum,            32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      chk("postrst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("postrst_in_ready",  32'(bus.in_ready),  32'd1);
    end

    // The pipeline must still work after the mid-stream reset.
    lat_on = 1'b1;
    send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, model(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0));
    idle(1);
    drain(STAGES + 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/csel_adder_pipe.md
Name: csel_adder_pipe

Overview:
- Parametrised, pipelined carry-select adder/subtractor; next generation of the team's fixed 32-bit, 4-bit-block carry-select adder.
- Splits the block-select carry chain across STAGES register stages.
- Adds add/sub mode, valid/ready flow control with backpressure, and zero/overflow flags.
- Sits between operand producers and the multiplier/accumulator datapath as the shared wide adder.

Parameters:
- WIDTH, 32: operand/result width; must be a multiple of BLK.
- BLK, 4: carry-select block width in bits.
- STAGES, 2: pipeline depth; NBLK = WIDTH/BLK; NBLK % STAGES == 0 and 1 <= STAGES <= NBLK.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block accepts operands this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in.
- sub  in  1  1 = subtract.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry-out (for subtraction, 1 = no borrow).
- overflow  out  1  signed overflow.
- zero  out  1  sum == 0.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All stage valid bits clear; out_valid=0.
  - sum=0, cout=0, overflow=0, zero=0.
  - in_ready follows the advance rule below, so it reads 1 while the pipeline is empty.
  - Reset asserted mid-operation discards all in-flight operations; no output is produced for them.
- Operand conditioning at input:
  - bx = b XOR {WIDTH{sub}}.
  - c0 = cin XOR sub.
  - sub=1, cin=0 gives a-b; sub=1, cin=1 gives a-b-1.
- Datapath:
  - Block 0 is a plain BLK-bit ripple add with c0.
  - Every block i>0 computes two sums, one with carry-in 0 and one with carry-in 1.
  - A mux selects between them using the carry out of block i-1.
- Pipelining:
  - Stage k (0..STAGES-1) resolves blocks k*NBLK/STAGES .. (k+1)*NBLK/STAGES-1.
  - Each stage register holds a valid bit, the resolved low sum bits, the still-unresolved a/bx slices, the block carry, and the sign bits of a/bx.
  - Stage STAGES-1 drives the output register.
- Latency: exactly STAGES cycles from an accepted input (in_valid && in_ready) to out_valid, given out_ready held high.
- Throughput: one operation per cycle.
- Flow control (global stall):
  - advance = !out_valid || out_ready; in_ready = advance.
  - When advance=0, every stage holds its value, and in_valid/operands are ignored.
  - When advance=1, each stage loads from the previous one.
  - Bubbles (valid=0) propagate as bubbles.
  - out_valid may fall only after a handshake; sum/cout/overflow/zero are stable while out_valid && !out_ready.
- Flags:
  - cout = carry out of the top block.
  - overflow = (a[MSB]==bx[MSB]) && (sum[MSB]!=a[MSB]).
  - zero = (sum==0).
  - All flags are registered alongside sum.
- Arithmetic is modulo 2^WIDTH; results wrap. The wrap-around is reported only via cout/overflow.
- Simultaneous events: output handshake and new input in the same cycle is a legal full-throughput case; both are taken and nothing is lost.

Optional Feature:
- Macro: CSEL_ADDER_SAT_EN.
- When defined:
  - Adds input port sat (1 bit), captured with the operands.
  - If sat=1 and overflow=1, sum is clamped: to 0x7FF..F when a[MSB]=0, to 0x800..0 when a[MSB]=1.
  - overflow is still reported as 1; zero is computed on the clamped value.
- When undefined:
  - No sat port; results always wrap.

Test Plan:
- Reset, then idle: out_valid=0, in_ready=1, sum=0; assert rst_n=0 mid-stream with 2 ops in flight -> no output emerges after release.
- WIDTH=32, STAGES=2, a=0xFFFF_FFFF, b=0x1, cin=0, sub=0 -> sum=0, cout=1, zero=1, overflow=0, exactly 2 cycles after acceptance.
- a=0x7FFF_FFFF, b=0x1, add -> sum=0x8000_0000, overflow=1; a=0x5, b=0x7, sub=1 -> sum=0xFFFF_FFFE, cout=0; a=0x7, b=0x5, sub=1 -> sum=0x2, cout=1.
- Back-to-back 100 random ops with out_ready=1 -> one result per cycle, in order, matching a±b±cin reference model.
- out_ready toggled randomly (held 0 for 3 cycles) -> in_ready=0 while stalled, output stable, no loss or duplication.
- With CSEL_ADDER_SAT_EN, sat=1, a=0x8000_0000, b=0x1, sub=1 -> sum=0x8000_0000, overflow=1; with sat=0 -> sum=0x7FFF_FFFF.
